// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter that shares the register file's
// single write port among NUM_REQ requesters. One winner per cycle is
// registered onto the write-port outputs. A hold input freezes arbitration,
// and a saturating counter tracks cycles that have contention.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_hold,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [DATA_W-1:0]         o_wr_data,
    output logic [ID_W-1:0]           o_grant_id,
    output logic [CNT_W-1:0]          o_contention_cnt
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [ID_W-1:0]    r_grant_id;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_ptr_next;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_multi;

    // Pick the first valid requester scanning upward from rr_ptr with wrap.
    // Only valid/hold/reset/rr_ptr feed this block, so ready never depends
    // on the request payload.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_any   = 1'b0;
        w_win   = '0;
        if (!i_reset && !i_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!w_any && i_req_valid[idx]) begin
                    w_any        = 1'b1;
                    w_win        = ID_W'(idx);
                    w_grant[idx] = 1'b1;
                end
            end
        end
    end

    // Route the winner's address and data toward the output registers.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer successor of the winner, plus "two or more requests" detect
    // (v & (v-1) is nonzero exactly when at least two bits are set).
    always_comb begin
        w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
        w_multi    = |(i_req_valid & (i_req_valid - NUM_REQ'(1)));
    end

    // Write-port registers, round-robin pointer and contention counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_any) begin
                // Register 0 is hard-wired: accept the write but suppress it.
                r_wr_en    <= (w_sel_addr != '0);
                r_wr_addr  <= w_sel_addr;
                r_wr_data  <= w_sel_data;
                r_grant_id <= w_win;
                r_rr_ptr   <= w_ptr_next;
            end else begin
                r_wr_en    <= 1'b0;
            end
            if (w_multi && !i_hold && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_req_ready      = w_grant;
    assign o_wr_en          = r_wr_en;
    assign o_wr_addr        = r_wr_addr;
    assign o_wr_data        = r_wr_data;
    assign o_grant_id       = r_grant_id;
    assign o_contention_cnt = r_cnt;

endmodule
